// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared lose-screen constants, FSM state type and 16-colour palette
package frogger_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FADE_IN,
    HOLD,
    WAIT_RESTART
  } lose_state_t;

  localparam int LOSE_W           = 224;
  localparam int LOSE_H           = 256;
  localparam int LOSE_X0          = 208;
  localparam int LOSE_Y0          = 112;
  localparam int HOLD_FRAMES      = 120;
  localparam int FADE_STEP_FRAMES = 8;

  // Index 0 is the transparent colour; the overlay never shows it.
  localparam logic [23:0] LOSE_PALETTE [16] = '{
    24'h000000, 24'hFF8040, 24'hFFFFFF, 24'hFF0000,
    24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'h00FFFF,
    24'hFF00FF, 24'h808080, 24'hC0C0C0, 24'h400000,
    24'h004000, 24'h000040, 24'h804020, 24'h102030
  };

endpackage

// File: rtl/lose_screen_ctrl_if.sv
// rtl/lose_screen_ctrl_if.sv - raster, lose-image ROM and overlay pixel bundle
interface lose_screen_ctrl_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [15:0] rom_addr;
  logic [3:0]  rom_data;
  logic [7:0]  Red;
  logic [7:0]  Green;
  logic [7:0]  Blue;
  logic        overlay_valid;

  modport master (
    output DrawX, DrawY, rom_data,
    input  rom_addr, Red, Green, Blue, overlay_valid
  );

  modport slave (
    input  DrawX, DrawY, rom_data,
    output rom_addr, Red, Green, Blue, overlay_valid
  );
endinterface

// File: rtl/lose_palette.sv
// rtl/lose_palette.sv - combinational 4-bit palette index to 24-bit RGB lookup
module lose_palette
  import frogger_pkg::*;
(
  input  logic [3:0]  index,
  output logic [23:0] rgb
);
  assign rgb = LOSE_PALETTE[index];
endmodule

// File: rtl/lose_screen_ctrl.sv
// rtl/lose_screen_ctrl.sv - lose-screen FSM and 2-stage overlay pipeline; LOSE_FADE_EN enables the fade-in
module lose_screen_ctrl
  import frogger_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               game_over,
  input  logic               frame_start,
  input  logic               restart_key,
  output logic               restart_done,
  lose_screen_ctrl_if.slave  vid
);

  lose_state_t state;
  logic [6:0]  hold_cnt;
  logic [1:0]  fade_level;
  logic [1:0]  eff_fade;
  logic [1:0]  shift;

`ifdef LOSE_FADE_EN
  logic [2:0]  fade_cnt;
`else
  assign fade_level = 2'd3;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      restart_done <= 1'b0;
`ifdef LOSE_FADE_EN
      fade_level   <= '0;
      fade_cnt     <= '0;
`endif
    end else begin
      restart_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start && game_over) begin
            hold_cnt <= '0;
`ifdef LOSE_FADE_EN
            state      <= FADE_IN;
            fade_level <= '0;
            fade_cnt   <= '0;
`else
            state      <= HOLD;
`endif
          end
        end
`ifdef LOSE_FADE_EN
        FADE_IN: begin
          if (frame_start) begin
            if (fade_cnt == 3'(FADE_STEP_FRAMES - 1)) begin
              fade_cnt <= '0;
              if (fade_level == 2'd3) begin
                state    <= HOLD;
                hold_cnt <= '0;
              end else begin
                fade_level <= fade_level + 2'd1;
              end
            end else begin
              fade_cnt <= fade_cnt + 3'd1;
            end
          end
        end
`endif
        HOLD: begin
          if (frame_start) begin
            if (hold_cnt == 7'(HOLD_FRAMES - 1)) begin
              state <= WAIT_RESTART;
            end else begin
              hold_cnt <= hold_cnt + 7'd1;
            end
          end
        end
        WAIT_RESTART: begin
          // restart_key takes priority over any coincident frame_start
          if (restart_key) begin
            state        <= IDLE;
            restart_done <= 1'b1;
            hold_cnt     <= '0;
`ifdef LOSE_FADE_EN
            fade_level   <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 0: window test and ROM address
  logic       in_win;
  logic       win_d;
  logic [9:0] dx;
  logic [9:0] dy;

  assign dx = vid.DrawX - 10'(LOSE_X0);
  assign dy = vid.DrawY - 10'(LOSE_Y0);
  assign in_win = (vid.DrawX >= 10'(LOSE_X0)) && (vid.DrawX <= 10'(LOSE_X0 + LOSE_W - 1)) &&
                  (vid.DrawY >= 10'(LOSE_Y0)) && (vid.DrawY <= 10'(LOSE_Y0 + LOSE_H - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vid.rom_addr <= '0;
      win_d        <= 1'b0;
    end else begin
      vid.rom_addr <= in_win ? (16'(dy) * 16'(LOSE_W) + 16'(dx)) : 16'd0;
      win_d        <= in_win;
    end
  end

  // Stage 1 -> 2: palette, fade shift, registered overlay
  logic [23:0] pal_rgb;
  logic        ov_next;

  lose_palette u_palette (
    .index (vid.rom_data),
    .rgb   (pal_rgb)
  );

  assign eff_fade = (state == FADE_IN) ? fade_level : 2'd3;
  assign shift    = 2'd3 - eff_fade;
  assign ov_next  = (state != IDLE) && win_d && (vid.rom_data != 4'd0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vid.Red           <= '0;
      vid.Green         <= '0;
      vid.Blue          <= '0;
      vid.overlay_valid <= 1'b0;
    end else begin
      vid.overlay_valid <= ov_next;
      vid.Red           <= ov_next ? (pal_rgb[23:16] >> shift) : 8'd0;
      vid.Green         <= ov_next ? (pal_rgb[15:8]  >> shift) : 8'd0;
      vid.Blue          <= ov_next ? (pal_rgb[7:0]   >> shift) : 8'd0;
    end
  end

endmodule

// File: tb/tb_lose_screen_ctrl.sv
// tb/tb_lose_screen_ctrl.sv - directed self-checking bench for lose_screen_ctrl
module tb_lose_screen_ctrl;
  import frogger_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n;
  logic game_over;
  logic frame_start;
  logic restart_key;
  logic restart_done;
  int   n_pass  = 0;
  int   n_total = 0;

  lose_screen_ctrl_if vif ();

  // ROM model: palette index is the low nibble of the address
  assign vif.rom_data = vif.rom_addr[3:0];

  lose_screen_ctrl dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .game_over    (game_over),
    .frame_start  (frame_start),
    .restart_key  (restart_key),
    .restart_done (restart_done),
    .vid          (vif)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic frames(input int n, input logic rk);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      restart_key = rk;
      tick();
      frame_start = 1'b0;
      restart_key = 1'b0;
    end
  endtask

  task automatic px(input string tag, input int x, input int y, input int exp_addr,
                    input int r, input int g, input int b, input int ov);
    vif.DrawX = 10'(x);
    vif.DrawY = 10'(y);
    tick();
    chk({tag, "_addr"}, 32'(vif.rom_addr), 32'(exp_addr));
    tick();
    chk({tag, "_red"},   32'(vif.Red),           32'(r));
    chk({tag, "_green"}, 32'(vif.Green),         32'(g));
    chk({tag, "_blue"},  32'(vif.Blue),          32'(b));
    chk({tag, "_ov"},    32'(vif.overlay_valid), 32'(ov));
  endtask

  initial begin
    Reset_n     = 1'b0;
    game_over   = 1'b0;
    frame_start = 1'b0;
    restart_key = 1'b0;
    vif.DrawX   = '0;
    vif.DrawY   = '0;
    #2;
    chk("rst_addr",  32'(vif.rom_addr), 0);
    chk("rst_red",   32'(vif.Red), 0);
    chk("rst_green", 32'(vif.Green), 0);
    chk("rst_blue",  32'(vif.Blue), 0);
    chk("rst_ov",    32'(vif.overlay_valid), 0);
    chk("rst_done",  32'(restart_done), 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    tick();
    tick();
    Reset_n = 1'b1;
    tick();

    game_over = 1'b1;
    tick(); tick(); tick();
    chk("go_alone_idle", 32'(dut.state), 32'(IDLE));
    game_over = 1'b0;
    frames(1, 1'b0);
    chk("fs_alone_idle", 32'(dut.state), 32'(IDLE));

    game_over = 1'b1;
    frames(1, 1'b0);
`ifdef LOSE_FADE_EN
    chk("enter_fade", 32'(dut.state), 32'(FADE_IN));
    chk("fade_lvl0",  32'(dut.fade_level), 0);
    px("fade0", 209, 112, 1, 'h1F, 'h10, 'h08, 1);
    frames(31, 1'b0);
    chk("fade31_state", 32'(dut.state), 32'(FADE_IN));
    chk("fade31_lvl",   32'(dut.fade_level), 3);
    px("fade3", 211, 112, 3, 'hFF, 'h00, 'h00, 1);
    frames(1, 1'b0);
    chk("enter_hold", 32'(dut.state), 32'(HOLD));
`else
    chk("enter_hold", 32'(dut.state), 32'(HOLD));
    px("hold_px", 209, 112, 1, 'hFF, 'h80, 'h40, 1);
`endif

    game_over = 1'b0;
    frames(99, 1'b0);
    frames(1, 1'b1);
    chk("hold_rk_ignored", 32'(dut.state), 32'(HOLD));
    frames(19, 1'b0);
    chk("hold_119", 32'(dut.state), 32'(HOLD));
    frames(1, 1'b0);
    chk("wait_reached", 32'(dut.state), 32'(WAIT_RESTART));

    px("corner", 431, 367, 57343, 'h10, 'h20, 'h30, 1);
    px("origin", 208, 112, 0, 0, 0, 0, 0);
    px("left_out", 207, 200, 0, 0, 0, 0, 0);
    px("below", 300, 368, 0, 0, 0, 0, 0);
    px("white", 210, 112, 2, 'hFF, 'hFF, 'hFF, 1);

    restart_key = 1'b1;
    frame_start = 1'b1;
    tick();
    chk("restart_done_hi", 32'(restart_done), 1);
    chk("restart_idle",    32'(dut.state), 32'(IDLE));
    restart_key = 1'b0;
    frame_start = 1'b0;
    tick();
    chk("restart_done_lo", 32'(restart_done), 0);
    px("idle_px", 209, 112, 1, 0, 0, 0, 0);

    game_over = 1'b1;
    frames(1, 1'b0);
`ifdef LOSE_FADE_EN
    frames(32, 1'b0);
`endif
    frames(5, 1'b0);
    chk("rehold", 32'(dut.state), 32'(HOLD));
    px("pre_rst", 209, 112, 1, 'hFF, 'h80, 'h40, 1);
    @(posedge Clk);
    #4;
    Reset_n = 1'b0;
    #1;
    chk("arst_addr",  32'(vif.rom_addr), 0);
    chk("arst_red",   32'(vif.Red), 0);
    chk("arst_green", 32'(vif.Green), 0);
    chk("arst_blue",  32'(vif.Blue), 0);
    chk("arst_ov",    32'(vif.overlay_valid), 0);
    chk("arst_state", 32'(dut.state), 32'(IDLE));
    chk("arst_hold",  32'(dut.hold_cnt), 0);
    #1;
    Reset_n = 1'b1;
    tick();
    chk("post_rst_addr", 32'(vif.rom_addr), 1);
    chk("post_rst_ov1",  32'(vif.overlay_valid), 0);
    tick();
    chk("post_rst_ov2",  32'(vif.overlay_valid), 0);
    chk("post_rst_state", 32'(dut.state), 32'(IDLE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
